// File: rtl/midi_pkg.sv
// midi_pkg
//   Shared constants and helpers for the MIDI SysEx config-dump query.
//   Holds the MIDI status constants, the manufacturer/magic IDs, the
//   request command and response code, the parser state encoding, and
//   small byte-classification / ROM helpers.
//   Ports: none (package).
package midi_pkg;

    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam logic [7:0] MANUF_ID  = 8'h7D;
    localparam logic [7:0] MAGIC_0   = 8'h2A;
    localparam logic [7:0] MAGIC_1   = 8'h4D;
    localparam logic [7:0] CMD_DUMP  = 8'h00;
    localparam logic [7:0] RESP_DUMP = 8'h40;

    localparam int unsigned REQ_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_HUNT = 3'd2,
        ST_HDR  = 3'd3,
        ST_BODY = 3'd4
    } state_e;

    // Real-time messages may be interleaved anywhere in a MIDI stream.
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= REALTIME_MIN;
    endfunction

    // Any non-real-time status byte (80..F7).
    function automatic logic is_status(input logic [7:0] b);
        return b[7] && (b < REALTIME_MIN);
    endfunction

    // Request ROM: F0 7D 2A 4D 00 F7.
    function automatic logic [7:0] req_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return SYSEX_START;
            3'd1:    return MANUF_ID;
            3'd2:    return MAGIC_0;
            3'd3:    return MAGIC_1;
            3'd4:    return CMD_DUMP;
            default: return SYSEX_END;
        endcase
    endfunction

    // Expected response header following F0: 7D 2A 4D 40.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return MANUF_ID;
            2'd1:    return MAGIC_0;
            2'd2:    return MAGIC_1;
            default: return RESP_DUMP;
        endcase
    endfunction

endpackage

// File: rtl/midi_sysex_query_if.sv
// midi_sysex_query_if
//   Bundles the query control, MIDI transmit/receive strobes and the
//   captured configuration fields.
//   Strobe semantics: txdv, rxdv, done and error are single-cycle strobes;
//   the data alongside a strobe is valid only in the cycle it is high, and
//   there is no back-pressure other than tx_busy, which holds off txdv.
//   Modports:
//     master - host side: drives start, tx_busy, rxdv, rxdata
//     slave  - query engine: drives txdv, txdata, busy, done, error, fields
interface midi_sysex_query_if;
    logic        start;
    logic        tx_busy;
    logic        txdv;
    logic [7:0]  txdata;
    logic        rxdv;
    logic [7:0]  rxdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  version;
    logic [6:0]  n_in;
    logic [6:0]  n_out;
    logic [13:0] bpm;

    modport master (
        output start, tx_busy, rxdv, rxdata,
        input  txdv, txdata, busy, done, error, version, n_in, n_out, bpm
    );

    modport slave (
        input  start, tx_busy, rxdv, rxdata,
        output txdv, txdata, busy, done, error, version, n_in, n_out, bpm
    );
endinterface

// File: rtl/midi_byte_seq.sv
// midi_byte_seq
//   ROM-indexed sender for the six-byte config-dump request.
//   Ports:
//     clk, rst  - clock, async active-high reset
//     go        - one-cycle pulse, restarts the sequence from byte 0
//     tx_busy   - transmitter busy; no strobe is issued while high
//     txdv      - one-cycle strobe, txdata valid
//     txdata    - request byte (0 when idle)
//     last      - high together with the txdv carrying the final F7
module midi_byte_seq
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       tx_busy,
    output logic       txdv,
    output logic [7:0] txdata,
    output logic       last
);

    logic       running;
    logic [2:0] idx;
    logic       txdv_q;

    // Combinational strobe so tx_busy is honoured in the very cycle the
    // byte is presented; txdv_q forces a gap cycle after every strobe.
    assign txdv   = running && !tx_busy && !txdv_q;
    assign txdata = running ? req_byte(idx) : 8'h00;
    assign last   = txdv && (idx == 3'(REQ_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            idx     <= 3'd0;
            txdv_q  <= 1'b0;
        end else begin
            txdv_q <= txdv;
            if (go) begin
                running <= 1'b1;
                idx     <= 3'd0;
            end else if (txdv) begin
                if (last) begin
                    running <= 1'b0;
                    idx     <= 3'd0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/midi_sysex_query.sv
// midi_sysex_query
//   Sends a SysEx config-dump request and parses the response
//   F0 7D 2A 4D 40 <ver> <n_in> <n_out> <bpm_msb> <bpm_lsb> F7.
//   Real-time bytes (F8..FF) are skipped everywhere.
//   Ports:
//     clk, rst   - clock, async active-high reset
//     bus        - midi_sysex_query_if.slave (start/tx/rx/status/fields)
//     state_dbg  - current parser state (midi_pkg::state_e encoding)
//   Build option: define MIDI_QUERY_TIMEOUT_EN to abort with error when no
//   complete response arrives within CLOCK/1000*TIMEOUT_MS cycles of
//   entering HUNT; without it the engine waits indefinitely.
module midi_sysex_query
    import midi_pkg::*;
#(
    parameter int unsigned CLOCK      = 12_000_000,
    parameter int unsigned TIMEOUT_MS = 100
) (
    input  logic               clk,
    input  logic               rst,
    midi_sysex_query_if.slave  bus,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] SEND = ST_SEND;
    localparam logic [2:0] HUNT = ST_HUNT;
    localparam logic [2:0] HDR  = ST_HDR;
    localparam logic [2:0] BODY = ST_BODY;

    logic [2:0]  state;
    logic [1:0]  hdr_idx;
    logic [2:0]  body_idx;
    logic        busy_q, done_q, error_q;
    logic [6:0]  version_q, n_in_q, n_out_q;
    logic [13:0] bpm_q;
    logic [6:0]  sh_ver, sh_in, sh_out, sh_msb, sh_lsb;

    logic       seq_go, seq_txdv, seq_last;
    logic [7:0] seq_txdata;
    logic       rx_ok;

    assign seq_go = (state == IDLE) && bus.start;
    assign rx_ok  = bus.rxdv && !is_realtime(bus.rxdata);

    midi_byte_seq u_seq (
        .clk     (clk),
        .rst     (rst),
        .go      (seq_go),
        .tx_busy (bus.tx_busy),
        .txdv    (seq_txdv),
        .txdata  (seq_txdata),
        .last    (seq_last)
    );

`ifdef MIDI_QUERY_TIMEOUT_EN
    localparam int unsigned TMO_LIMIT = CLOCK / 1000 * TIMEOUT_MS;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             hunting;
    logic             tmo_expired;

    assign hunting     = (state == HUNT) || (state == HDR) || (state == BODY);
    // Fires on the edge TMO_LIMIT cycles after HUNT entry.
    assign tmo_expired = hunting && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (hunting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic tmo_expired;
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hdr_idx   <= 2'd0;
            body_idx  <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            version_q <= 7'd0;
            n_in_q    <= 7'd0;
            n_out_q   <= 7'd0;
            bpm_q     <= 14'd0;
            sh_ver    <= 7'd0;
            sh_in     <= 7'd0;
            sh_out    <= 7'd0;
            sh_msb    <= 7'd0;
            sh_lsb    <= 7'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (tmo_expired) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            busy_q <= 1'b1;
                            state  <= SEND;
                        end
                    end
                    SEND: begin
                        if (seq_last) state <= HUNT;
                    end
                    HUNT: begin
                        if (rx_ok && bus.rxdata == SYSEX_START) begin
                            hdr_idx <= 2'd0;
                            state   <= HDR;
                        end
                    end
                    HDR: begin
                        if (rx_ok) begin
                            if (bus.rxdata == SYSEX_START) begin
                                hdr_idx <= 2'd0;
                            end else if (bus.rxdata == hdr_byte(hdr_idx)) begin
                                if (hdr_idx == 2'd3) begin
                                    body_idx <= 3'd0;
                                    state    <= BODY;
                                end else begin
                                    hdr_idx <= hdr_idx + 2'd1;
                                end
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    BODY: begin
                        if (rx_ok) begin
                            if (body_idx == 3'd5) begin
                                // Published fields change only on a
                                // well-formed terminator.
                                if (bus.rxdata == SYSEX_END) begin
                                    version_q <= sh_ver;
                                    n_in_q    <= sh_in;
                                    n_out_q   <= sh_out;
                                    bpm_q     <= {sh_msb, sh_lsb};
                                    done_q    <= 1'b1;
                                end else begin
                                    error_q <= 1'b1;
                                end
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end else if (is_status(bus.rxdata)) begin
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                case (body_idx)
                                    3'd0:    sh_ver <= bus.rxdata[6:0];
                                    3'd1:    sh_in  <= bus.rxdata[6:0];
                                    3'd2:    sh_out <= bus.rxdata[6:0];
                                    3'd3:    sh_msb <= bus.rxdata[6:0];
                                    default: sh_lsb <= bus.rxdata[6:0];
                                endcase
                                body_idx <= body_idx + 3'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.txdv    = seq_txdv;
    assign bus.txdata  = seq_txdata;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.error   = error_q;
    assign bus.version = version_q;
    assign bus.n_in    = n_in_q;
    assign bus.n_out   = n_out_q;
    assign bus.bpm     = bpm_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_midi_sysex_query.sv
// tb_midi_sysex_query
//   Self-checking bench for midi_sysex_query: request emission, response
//   parsing (fixed and randomized streams against a byte-level reference
//   model), real-time filtering, malformed bodies, reset abort and timeout.
module tb_midi_sysex_query;

    localparam int unsigned CLK_HZ = 12_000_000;
    localparam int unsigned TMO_MS = 1;
    localparam int unsigned LIMIT  = CLK_HZ / 1000 * TMO_MS;
    localparam logic [2:0]  S_HUNT = 3'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    midi_sysex_query_if bus();

    midi_sysex_query #(.CLOCK(CLK_HZ), .TIMEOUT_MS(TMO_MS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_q[$];
    int         done_cnt = 0, err_cnt = 0;
    int         done_cyc = 0, err_cyc = 0, hunt_cyc = 0;
    logic       prev_txdv = 1'b0;
    bit         tx_model_en = 0;
    int         txb_cnt = 0;

    logic [6:0]  exp_ver = 7'd0, exp_in = 7'd0, exp_out = 7'd0;
    logic [13:0] exp_bpm = 14'd0;

    int         m_kind;
    logic [6:0] m_f[5];

    logic [7:0] req_exp[6];
    initial begin
        req_exp[0] = 8'hF0; req_exp[1] = 8'h7D; req_exp[2] = 8'h2A;
        req_exp[3] = 8'h4D; req_exp[4] = 8'h00; req_exp[5] = 8'hF7;
    end

    // Monitor: collects transmitted bytes and outcome pulses.
    always @(negedge clk) begin
        if (bus.txdv === 1'b1) begin
            tx_q.push_back(bus.txdata);
            checks++;
            if (bus.tx_busy !== 1'b0 || prev_txdv !== 1'b0) begin
                errors++;
                $display("FAIL txdv_spacing: tx_busy=%b prev_txdv=%b, required 0 and 0",
                         bus.tx_busy, prev_txdv);
            end
            if (tx_model_en) txb_cnt = $urandom_range(0, 3);
        end
        prev_txdv = bus.txdv;
        if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (bus.error === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (bus.done === 1'b1 || bus.error === 1'b1) begin
            checks++;
            if ((bus.done === 1'b1 && bus.error === 1'b1) || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL pulse_excl: done=%b error=%b busy=%b, required one pulse with busy 0",
                         bus.done, bus.error, bus.busy);
            end
        end
    end

    // Transmitter model: busy for a random 0..3 cycles after each strobe.
    always @(posedge clk) begin
        #1;
        if (tx_model_en) begin
            bus.tx_busy = (txb_cnt > 0);
            if (txb_cnt > 0) txb_cnt--;
        end else begin
            bus.tx_busy = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1; bus.rxdv = 1'b1; bus.rxdata = b;
        @(posedge clk); #1; bus.rxdv = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$]);
        foreach (s[n]) send_rx(s[n]);
    endtask

    task automatic wait_hunt(output bit ok);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (state_dbg == S_HUNT) begin ok = 1; hunt_cyc = cyc; break; end
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        exp_ver = 7'd0; exp_in = 7'd0; exp_out = 7'd0; exp_bpm = 14'd0;
    endtask

    // ---------------- reference model ----------------
    // Scans the received byte list for the first completed response:
    // m_kind 0 = nothing yet, 1 = valid (fields in m_f), 2 = malformed body.
    task automatic model_run(input logic [7:0] s[$]);
        logic [7:0] q[$];
        logic [7:0] hdr[4];
        logic [7:0] v;
        int i, j, k;
        hdr[0] = 8'h7D; hdr[1] = 8'h2A; hdr[2] = 8'h4D; hdr[3] = 8'h40;
        m_kind = 0;
        foreach (s[n]) if (s[n] < 8'hF8) q.push_back(s[n]);
        i = 0;
        while (i < q.size()) begin
            if (q[i] != 8'hF0) begin i++; continue; end
            j = i + 1;
            k = 0;
            while (k < 4 && j < q.size()) begin
                if (q[j] == 8'hF0) begin k = 0; j++; end
                else if (q[j] == hdr[k]) begin k++; j++; end
                else break;
            end
            if (k < 4) begin i = j + 1; continue; end
            for (int b = 0; b < 6; b++) begin
                if (j + b >= q.size()) return;
                v = q[j + b];
                if (b < 5) begin
                    if (v >= 8'h80) begin m_kind = 2; return; end
                    m_f[b] = v[6:0];
                end else begin
                    m_kind = (v == 8'hF7) ? 1 : 2;
                    return;
                end
            end
            return;
        end
    endtask

    task automatic build_stream(output logic [7:0] s[$]);
        logic [7:0] raw[$];
        int mode, bad;
        repeat ($urandom_range(0, 4)) begin
            case ($urandom_range(0, 3))
                0:       raw.push_back(8'($urandom_range(0, 8'hEF)));
                1:       raw.push_back(8'h7D);
                2:       raw.push_back(8'hF0);
                default: raw.push_back(8'h40);
            endcase
        end
        raw.push_back(8'hF0); raw.push_back(8'h7D); raw.push_back(8'h2A);
        raw.push_back(8'h4D); raw.push_back(8'h40);
        mode = $urandom_range(0, 3);
        bad  = $urandom_range(0, 4);
        for (int b = 0; b < 5; b++) begin
            if (mode == 2 && b == bad) raw.push_back(8'($urandom_range(8'h80, 8'hF7)));
            else                       raw.push_back(8'($urandom_range(0, 127)));
        end
        raw.push_back(mode == 3 ? 8'($urandom_range(0, 127)) : 8'hF7);
        s.delete();
        foreach (raw[n]) begin
            s.push_back(raw[n]);
            if ($urandom_range(0, 3) == 0) s.push_back(8'($urandom_range(8'hF8, 8'hFF)));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.start = 1'b0; bus.rxdv = 1'b0; bus.rxdata = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus.txdv, bus.busy, bus.done, bus.error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 0000",
                     {bus.txdv, bus.busy, bus.done, bus.error});
        end
        checks++;
        if (bus.txdata !== 8'h00) begin
            errors++; $display("FAIL reset_txdata: got %h, required 00", bus.txdata);
        end
        checks++;
        if ({bus.version, bus.n_in, bus.n_out, bus.bpm} !== 35'd0) begin
            errors++;
            $display("FAIL reset_fields: got %0d %0d %0d %0d, required 0 0 0 0",
                     bus.version, bus.n_in, bus.n_out, bus.bpm);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d, required 0", state_dbg);
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        logic [7:0] s[$];
        int d0, e0;
        s = '{8'hF0, 8'h7D, 8'h2A, 8'h4D, 8'h40, 8'h05, 8'h01, 8'h02, 8'h00, 8'h10, 8'hF7};
        d0 = done_cnt; e0 = err_cnt;
        send_stream(s);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || bus.version !== exp_ver) begin
            errors++;
            $display("FAIL idle_ignore: done+%0d error+%0d version %0d, required 0 0 %0d",
                     done_cnt - d0, err_cnt - e0, bus.version, exp_ver);
        end
    endtask

    task automatic test_request();
        bit ok;
        logic [7:0] s[$];
        int d0, e0;
        tx_q.delete();
        pulse_start();
        wait_hunt(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL req_hunt: never reached HUNT, required within 200 cycles"); end
        checks++;
        if (tx_q.size() != 6) begin
            errors++; $display("FAIL req_count: got %0d bytes, required 6", tx_q.size());
        end
        for (int n = 0; n < 6 && n < tx_q.size(); n++) begin
            checks++;
            if (tx_q[n] !== req_exp[n]) begin
                errors++; $display("FAIL req_byte%0d: got %h, required %h", n, tx_q[n], req_exp[n]);
            end
        end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL req_busy: got %b, required 1", bus.busy); end
        // A second start while busy must not restart the request.
        pulse_start();
        s = '{8'hF0, 8'h7D, 8'h2A, 8'h4D, 8'h40, 8'h01, 8'h0F, 8'h0F, 8'h00, 8'h70, 8'hF7};
        d0 = done_cnt; e0 = err_cnt;
        send_stream(s);
        wait_outcome(d0, e0);
        exp_ver = 7'd1; exp_in = 7'd15; exp_out = 7'd15; exp_bpm = 14'd112;
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++; $display("FAIL resp_done: done+%0d error+%0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({bus.version, bus.n_in, bus.n_out, bus.bpm} !== {exp_ver, exp_in, exp_out, exp_bpm}) begin
            errors++;
            $display("FAIL resp_fields: got %0d %0d %0d %0d, required 1 15 15 112",
                     bus.version, bus.n_in, bus.n_out, bus.bpm);
        end
        checks++;
        if (tx_q.size() != 6) begin errors++; $display("FAIL start_ignored: got %0d bytes, required 6", tx_q.size()); end
    endtask

    task automatic test_realtime();
        bit ok;
        logic [7:0] base[$];
        logic [7:0] s[$];
        int d0, e0;
        base = '{8'hF0, 8'h7D, 8'h2A, 8'h4D, 8'h40, 8'h01, 8'h0F, 8'h0F, 8'h00, 8'h70, 8'hF7};
        foreach (base[n]) begin
            s.push_back(base[n]);
            s.push_back(8'($urandom_range(8'hF8, 8'hFF)));
        end
        pulse_start();
        wait_hunt(ok);
        d0 = done_cnt; e0 = err_cnt;
        send_stream(s);
        wait_outcome(d0, e0);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0 ||
            {bus.version, bus.n_in, bus.n_out, bus.bpm} !== {7'd1, 7'd15, 7'd15, 14'd112}) begin
            errors++;
            $display("FAIL realtime: done+%0d error+%0d fields %0d %0d %0d %0d, required 1 0 1 15 15 112",
                     done_cnt - d0, err_cnt - e0, bus.version, bus.n_in, bus.n_out, bus.bpm);
        end
    endtask

    task automatic test_malformed();
        bit ok;
        logic [7:0] s[$];
        int d0, e0;
        s = '{8'hF0, 8'h7D, 8'h2A, 8'h4D, 8'h40, 8'h01, 8'h0F, 8'h90};
        pulse_start();
        wait_hunt(ok);
        d0 = done_cnt; e0 = err_cnt;
        send_stream(s);
        wait_outcome(d0, e0);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            errors++; $display("FAIL malformed_err: done+%0d error+%0d, required 0 1", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({bus.version, bus.n_in, bus.n_out, bus.bpm} !== {exp_ver, exp_in, exp_out, exp_bpm}) begin
            errors++;
            $display("FAIL malformed_keep: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                     bus.version, bus.n_in, bus.n_out, bus.bpm, exp_ver, exp_in, exp_out, exp_bpm);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] s[$];
        int d0, e0;
        tx_model_en = 1;
        for (int it = 0; it < 25; it++) begin
            tx_q.delete();
            pulse_start();
            wait_hunt(ok);
            checks++;
            if (!ok || tx_q.size() != 6 || tx_q[0] !== 8'hF0 || tx_q[5] !== 8'hF7) begin
                errors++;
                $display("FAIL rand_req it%0d: hunt=%0d bytes=%0d, required 1 6", it, ok, tx_q.size());
            end
            build_stream(s);
            model_run(s);
            d0 = done_cnt; e0 = err_cnt;
            send_stream(s);
            wait_outcome(d0, e0);
            if (m_kind == 1) begin
                exp_ver = m_f[0]; exp_in = m_f[1]; exp_out = m_f[2]; exp_bpm = {m_f[3], m_f[4]};
            end
            checks++;
            if (done_cnt - d0 != (m_kind == 1 ? 1 : 0) || err_cnt - e0 != (m_kind == 2 ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_outcome it%0d: done+%0d error+%0d, required kind %0d",
                         it, done_cnt - d0, err_cnt - e0, m_kind);
            end
            checks++;
            if ({bus.version, bus.n_in, bus.n_out, bus.bpm} !== {exp_ver, exp_in, exp_out, exp_bpm}) begin
                errors++;
                $display("FAIL rand_fields it%0d: got %0d %0d %0d %0d, required %0d %0d %0d %0d", it,
                         bus.version, bus.n_in, bus.n_out, bus.bpm, exp_ver, exp_in, exp_out, exp_bpm);
            end
            if (m_kind == 0) do_reset();
        end
        tx_model_en = 0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] s[$];
        int d0, e0;
        tx_q.delete();
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (tx_q.size() >= 3) break;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.txdv !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_abort: txdv=%b busy=%b, required 0 0", bus.txdv, bus.busy);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        exp_ver = 7'd0; exp_in = 7'd0; exp_out = 7'd0; exp_bpm = 14'd0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (tx_q.size() != 3 || done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_quiet: bytes=%0d done+%0d error+%0d, required 3 0 0",
                     tx_q.size(), done_cnt - d0, err_cnt - e0);
        end
        tx_q.delete();
        pulse_start();
        wait_hunt(ok);
        checks++;
        if (!ok || tx_q.size() != 6 || tx_q[0] !== 8'hF0) begin
            errors++; $display("FAIL rst_resend: hunt=%0d bytes=%0d, required 1 6 starting F0", ok, tx_q.size());
        end
        s = '{8'hF0, 8'h7D, 8'h2A, 8'h4D, 8'h40, 8'h02, 8'h03, 8'h04, 8'h01, 8'h05, 8'hF7};
        d0 = done_cnt; e0 = err_cnt;
        send_stream(s);
        wait_outcome(d0, e0);
        exp_ver = 7'd2; exp_in = 7'd3; exp_out = 7'd4; exp_bpm = 14'd133;
        checks++;
        if ({bus.version, bus.n_in, bus.n_out, bus.bpm} !== {exp_ver, exp_in, exp_out, exp_bpm}) begin
            errors++;
            $display("FAIL rst_after: got %0d %0d %0d %0d, required 2 3 4 133",
                     bus.version, bus.n_in, bus.n_out, bus.bpm);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0, e0;
        pulse_start();
        wait_hunt(ok);
        d0 = done_cnt; e0 = err_cnt;
        for (int c = 0; c < LIMIT + 50; c++) begin
            @(negedge clk); #1;
            if (err_cnt != e0) break;
        end
`ifdef MIDI_QUERY_TIMEOUT_EN
        checks++;
        if (err_cnt - e0 != 1 || err_cyc - hunt_cyc != LIMIT || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout: error+%0d after %0d cycles, required 1 after %0d",
                     err_cnt - e0, err_cyc - hunt_cyc, LIMIT);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b, required 0", bus.busy); end
`else
        checks++;
        if (err_cnt != e0 || done_cnt != d0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: error+%0d done+%0d busy=%b, required 0 0 1",
                     err_cnt - e0, done_cnt - d0, bus.busy);
        end
        do_reset();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_timeout_rst: busy=%b, required 0", bus.busy); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_ignore();
        test_request();
        test_realtime();
        test_malformed();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
